// File: rtl/sa_islip_pktlock.sv
// sa_islip_pktlock
// ----------------
// Separable input-first switch allocator for the NoC router. Every cycle it
// matches input-port virtual channels to output ports. Each input port gets
// at most one grant and each output port gets at most one grant.
//   - Input stage: each input port picks one eligible VC, round-robin from
//     in_ptr. A VC that owns a packet lock wins regardless of the pointer.
//   - Output stage: each output picks one input port among the input-stage
//     winners that target it, round-robin from out_ptr.
//   - Pointers move iSLIP-style, and only on head (unlocked) grants.
//   - A granted non-tail flit locks its output to that VC until the tail goes.
//   - out_ready masks an output for the current cycle only.
//
// Ports
//   clk         clock
//   rst         asynchronous, active-low reset
//   req_valid   [NREQ]       VC k = p*VCS+v has a flit ready
//   req_oport   [NREQ][PW]   requested output of VC k (>= PORTS: no request)
//   req_tail    [NREQ]       requesting flit is the packet tail
//   out_ready   [PORTS]      output o has downstream credit this cycle
//   gnt         [NREQ]       VC k sends its flit this cycle (one-hot per port)
//   xbar_valid  [PORTS]      output o carries a flit this cycle
//   xbar_sel    [PORTS][PW]  input port driving output o (0 when idle)
//
// Grants are purely combinational from the inputs and the registered state.
// Nothing in the block feeds gnt back into the request logic.

module sa_islip_pktlock #(
  parameter int PORTS = 5,
  parameter int VCS   = 4,
  localparam int NREQ = PORTS * VCS,
  localparam int PW   = (PORTS > 1) ? $clog2(PORTS) : 1,
  localparam int VW   = (VCS > 1) ? $clog2(VCS) : 1,
  localparam int KW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0][PW-1:0]    req_oport,
  input  logic [NREQ-1:0]            req_tail,
  input  logic [PORTS-1:0]           out_ready,
  output logic [NREQ-1:0]            gnt,
  output logic [PORTS-1:0]           xbar_valid,
  output logic [PORTS-1:0][PW-1:0]   xbar_sel
);

  // ------------------------------------------------------------------
  // Registered state
  // ------------------------------------------------------------------
  logic [VW-1:0]    r_in_ptr  [PORTS];
  logic [PW-1:0]    r_out_ptr [PORTS];
  logic [PORTS-1:0] r_lock_vld;
  logic [KW-1:0]    r_lock_vc [PORTS];

  // ------------------------------------------------------------------
  // Combinational signals
  // ------------------------------------------------------------------
  logic [NREQ-1:0]  w_elig;      // VC may be granted this cycle
  logic [NREQ-1:0]  w_owner;     // eligible and owns the lock on its output
  logic [PORTS-1:0] w_in_vld;    // input stage found a winner
  logic [VW-1:0]    w_in_vc   [PORTS];
  logic [PW-1:0]    w_in_op   [PORTS];
  logic [PORTS-1:0] w_in_tail;
  logic [PORTS-1:0] w_out_vld;   // output stage found a winner
  logic [PW-1:0]    w_out_port [PORTS];
  logic [PORTS-1:0] w_port_gnt;  // input port p won its output

  // ------------------------------------------------------------------
  // Eligibility
  // ------------------------------------------------------------------
  // The range check comes first, so an out-of-range req_oport never
  // selects a ready or lock bit.
  always_comb begin
    w_elig  = '0;
    w_owner = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[k] && (int'(req_oport[k]) < PORTS)) begin
        if (out_ready[req_oport[k]]) begin
          if (!r_lock_vld[req_oport[k]]) begin
            w_elig[k] = 1'b1;
          end else if (r_lock_vc[req_oport[k]] == KW'(k)) begin
            w_elig[k]  = 1'b1;
            w_owner[k] = 1'b1;
          end
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Input stage
  // ------------------------------------------------------------------
  // Round-robin is done as "smallest rotated distance from the pointer".
  // This keeps every array index a loop constant. Lock owners are ranked
  // separately and take precedence over the plain round-robin choice.
  always_comb begin
    int d;
    int own_d;
    int any_d;
    int sel_own;
    int sel_any;
    int sel;
    d       = 0;
    own_d   = 0;
    any_d   = 0;
    sel_own = 0;
    sel_any = 0;
    sel     = 0;
    for (int p = 0; p < PORTS; p++) begin
      w_in_vld[p]  = 1'b0;
      w_in_vc[p]   = '0;
      w_in_op[p]   = '0;
      w_in_tail[p] = 1'b0;
      own_d   = VCS;
      any_d   = VCS;
      sel_own = 0;
      sel_any = 0;
      for (int v = 0; v < VCS; v++) begin
        d = v - int'(r_in_ptr[p]);
        if (d < 0) d = d + VCS;
        if (w_owner[p*VCS+v] && (d < own_d)) begin
          own_d   = d;
          sel_own = v;
        end
        if (w_elig[p*VCS+v] && (d < any_d)) begin
          any_d   = d;
          sel_any = v;
        end
      end
      sel = (own_d < VCS) ? sel_own : sel_any;
      w_in_vld[p] = (any_d < VCS);
      w_in_vc[p]  = VW'(sel);
      for (int v = 0; v < VCS; v++) begin
        if (v == sel) begin
          w_in_op[p]   = req_oport[p*VCS+v];
          w_in_tail[p] = req_tail[p*VCS+v];
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Output stage
  // ------------------------------------------------------------------
  // A locked output never sees a non-owner candidate. Eligibility has
  // already removed every other VC that targets it.
  always_comb begin
    int d;
    int best_d;
    int best_p;
    d          = 0;
    best_d     = 0;
    best_p     = 0;
    w_port_gnt = '0;
    for (int o = 0; o < PORTS; o++) begin
      w_out_vld[o]  = 1'b0;
      w_out_port[o] = '0;
      best_d = PORTS;
      best_p = 0;
      for (int p = 0; p < PORTS; p++) begin
        d = p - int'(r_out_ptr[o]);
        if (d < 0) d = d + PORTS;
        if (w_in_vld[p] && (int'(w_in_op[p]) == o) && (d < best_d)) begin
          best_d = d;
          best_p = p;
        end
      end
      if (best_d < PORTS) begin
        w_out_vld[o]  = 1'b1;
        w_out_port[o] = PW'(best_p);
        for (int p = 0; p < PORTS; p++) begin
          if (p == best_p) w_port_gnt[p] = 1'b1;
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Outputs. They are forced idle while reset is held, even though
  // requests may still be present.
  // ------------------------------------------------------------------
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
    localparam int GP = gi / VCS;
    localparam int GV = gi % VCS;
    assign gnt[gi] = rst & w_port_gnt[GP] & (w_in_vc[GP] == VW'(GV));
  end

  for (genvar gi = 0; gi < PORTS; gi++) begin : g_xbar
    assign xbar_valid[gi] = rst & w_out_vld[gi];
    assign xbar_sel[gi]   = (rst & w_out_vld[gi]) ? w_out_port[gi] : '0;
  end

  // ------------------------------------------------------------------
  // State update
  // ------------------------------------------------------------------
  // Only outputs that made a grant change state. The pointers move only on
  // head grants, i.e. when the output was not already locked. An input winner
  // that lost at the output stage leaves in_ptr alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < PORTS; p++) begin
        r_in_ptr[p]  <= '0;
        r_out_ptr[p] <= '0;
        r_lock_vc[p] <= '0;
      end
      r_lock_vld <= '0;
    end else begin
      for (int o = 0; o < PORTS; o++) begin
        for (int p = 0; p < PORTS; p++) begin
          if (w_out_vld[o] && (w_out_port[o] == PW'(p))) begin
            if (!r_lock_vld[o]) begin
              r_in_ptr[p]  <= (int'(w_in_vc[p]) == VCS - 1) ? '0
                                                            : w_in_vc[p] + VW'(1);
              r_out_ptr[o] <= PW'((p + 1) % PORTS);
            end
            if (w_in_tail[p]) begin
              r_lock_vld[o] <= 1'b0;
            end else begin
              r_lock_vld[o] <= 1'b1;
              r_lock_vc[o]  <= KW'(p * VCS + int'(w_in_vc[p]));
            end
          end
        end
      end
    end
  end

endmodule
